// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - passive decoder for a multiplexed active-low seven-segment display bus
//
// Samples the segment and anode lines every cycle. Once a pattern has been
// stable for STABLE_CYCLES samples, it decodes the selected digit back to a
// hex nibble. Segment patterns outside the 16 hex codes are reported on err.
//
// Optional feature macro: SEG7_DP_EN
//   When defined, seg_n carries the decimal point on bit 7, and the dp output
//   holds the captured decimal points.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   seg_n        active-low segments, bit0=a .. bit6=g (bit7=dp with SEG7_DP_EN)
//   an_n         active-low digit enables, exactly one low selects a digit
//   clear        synchronous clear of captured data (sampler/FSM untouched)
//   value        decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  bit i set while digit i holds a legal decode
//   frame_valid  one-cycle pulse: last digit captured with all digits valid
//   err          one-cycle pulse: illegal segment pattern captured
//   err_digit    digit index of the most recent err
//   dp           captured decimal points (SEG7_DP_EN only)
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SEG7_DP_EN
  input  logic [7:0]            seg_n,
`else
  input  logic [6:0]            seg_n,
`endif
  input  logic [DIGITS-1:0]     an_n,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err,
  output logic [2:0]            err_digit
`ifdef SEG7_DP_EN
  ,
  output logic [DIGITS-1:0]     dp
`endif
);

`ifdef SEG7_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam int SW = SEG_W + DIGITS;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_SETTLE  = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  // sampler and stability tracking
  logic [SW-1:0]         r_samp;
  logic [SW-1:0]         r_samp_d;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_next;
  logic                  w_changed;
  state_t                r_state;
  state_t                w_state_next;

  // capture path
  logic [DIGITS-1:0]     w_an;
  logic [6:0]            w_seg;
  logic [DIGITS-1:0]     w_onehot;
  logic [3:0]            w_zero_cnt;
  logic [2:0]            w_idx;
  logic                  w_sel_ok;
  logic                  w_legal;
  logic [3:0]            w_nibble;
  logic                  w_capture;
  logic                  w_all_valid;
  logic [4*DIGITS-1:0]   w_value_wr;

  // captured state
  logic [4*DIGITS-1:0]   r_value;
  logic [DIGITS-1:0]     r_digit_valid;
  logic                  r_frame_valid;
  logic                  r_err;
  logic [2:0]            r_err_digit;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]     r_dp;
  logic [DIGITS-1:0]     w_dp_wr;
`endif

  assign w_changed = (r_samp != r_samp_d);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed) begin
      w_cnt_next = 8'd1;
    end else if (r_cnt < STABLE) begin
      w_cnt_next = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_samp   <= '1;
      r_samp_d <= '1;
      r_cnt    <= 8'd0;
    end else begin
      r_samp   <= {an_n, seg_n};
      r_samp_d <= r_samp;
      r_cnt    <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_SETTLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The SETTLE exit looks at the count being loaded this edge, so the
  // CAPTURE cycle writes on edge STABLE_CYCLES+1 after the pattern's first
  // sample. A change seen while in CAPTURE goes straight back to SETTLE so
  // a short-dwell next digit is not missed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SETTLE:  if (w_cnt_next == STABLE) w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = w_changed ? S_SETTLE : S_HOLD;
      S_HOLD:    if (w_changed) w_state_next = S_SETTLE;
      default:   w_state_next = S_SETTLE;
    endcase
  end

  // r_samp_d is the pattern that was stable through the window; r_samp may
  // already hold the next pattern during CAPTURE.
  assign w_an     = r_samp_d[SW-1:SEG_W];
  assign w_seg    = r_samp_d[6:0];
  assign w_onehot = ~w_an;

  always_comb begin
    w_zero_cnt = 4'd0;
    w_idx      = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!w_an[i]) begin
        w_zero_cnt = w_zero_cnt + 4'd1;
        w_idx      = 3'(i);
      end
    end
  end

  assign w_sel_ok = (w_zero_cnt == 4'd1);

  always_comb begin
    w_legal  = 1'b1;
    w_nibble = 4'h0;
    case (w_seg)
      7'b1000000: w_nibble = 4'h0;
      7'b1111001: w_nibble = 4'h1;
      7'b0100100: w_nibble = 4'h2;
      7'b0110000: w_nibble = 4'h3;
      7'b0011001: w_nibble = 4'h4;
      7'b0010010: w_nibble = 4'h5;
      7'b0000010: w_nibble = 4'h6;
      7'b1111000: w_nibble = 4'h7;
      7'b0000000: w_nibble = 4'h8;
      7'b0010000: w_nibble = 4'h9;
      7'b0001000: w_nibble = 4'hA;
      7'b0000011: w_nibble = 4'hB;
      7'b1000110: w_nibble = 4'hC;
      7'b0100001: w_nibble = 4'hD;
      7'b0000110: w_nibble = 4'hE;
      7'b0001110: w_nibble = 4'hF;
      default:    w_legal  = 1'b0;
    endcase
  end

  assign w_capture   = (r_state == S_CAPTURE) && w_sel_ok;
  assign w_all_valid = &(r_digit_valid | w_onehot);

  always_comb begin
    w_value_wr = r_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_onehot[i]) begin
        w_value_wr[4*i +: 4] = w_nibble;
      end
    end
  end

`ifdef SEG7_DP_EN
  assign w_dp_wr = (r_dp & ~w_onehot) | (w_onehot & {DIGITS{~r_samp_d[7]}});
`endif

  // clear wins over a same-cycle capture and also suppresses its pulses,
  // since the data they would describe is being discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value       <= '0;
      r_digit_valid <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_err_digit   <= 3'd0;
`ifdef SEG7_DP_EN
      r_dp          <= '0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      if (clear) begin
        r_value       <= '0;
        r_digit_valid <= '0;
        r_err_digit   <= 3'd0;
`ifdef SEG7_DP_EN
        r_dp          <= '0;
`endif
      end else if (w_capture) begin
        if (w_legal) begin
          r_value       <= w_value_wr;
          r_digit_valid <= r_digit_valid | w_onehot;
          r_frame_valid <= w_onehot[DIGITS-1] && w_all_valid;
`ifdef SEG7_DP_EN
          r_dp          <= w_dp_wr;
`endif
        end else begin
          r_digit_valid <= r_digit_valid & ~w_onehot;
          r_err         <= 1'b1;
          r_err_digit   <= w_idx;
        end
      end
    end
  end

  assign value       = r_value;
  assign digit_valid = r_digit_valid;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;
  assign err_digit   = r_err_digit;
`ifdef SEG7_DP_EN
  assign dp          = r_dp;
`endif

endmodule
